// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// It combines RAW data hazards, taken branches and a wait-stated memory FSM with a timeout.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH = 4,
   parameter int MEM_TIMEOUT    = 15,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_Id_Valid,
   input  logic [REG_ADDR_WIDTH-1:0] i_Src1,
   input  logic [REG_ADDR_WIDTH-1:0] i_Src2,
   input  logic                      i_Two_Src,
   input  logic [REG_ADDR_WIDTH-1:0] i_Exe_Dest,
   input  logic                      i_Exe_Wb_En,
   input  logic                      i_Exe_Mem_Read,
   input  logic [REG_ADDR_WIDTH-1:0] i_Mem_Dest,
   input  logic                      i_Mem_Wb_En,
   input  logic                      i_Forward_En,
   input  logic                      i_Branch_Taken,
   input  logic                      i_Mem_Req,
   input  logic                      i_Mem_Ready,
   output logic                      o_Hazard,
   output logic                      o_Flush,
   output logic                      o_Freeze,
   output logic                      o_Mem_Timeout,
   output logic [CNT_WIDTH-1:0]      o_Stall_Count
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ERROR = 2'd2
   } mem_state_t;

   mem_state_t        state, state_next;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
   logic              freeze;
   logic              hz;
   logic              exe_match1, exe_match2, mem_match1, mem_match2;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // The wait counter holds the number of frozen cycles spent so far on the current access.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      freeze        = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (i_Mem_Req && !i_Mem_Ready) begin
               freeze        = 1'b1;
               state_next    = S_WAIT;
               wait_cnt_next = WAIT_W'(1);
            end
         end
         S_WAIT: begin
            freeze = !i_Mem_Ready;
            if (i_Mem_Ready) begin
               state_next    = S_IDLE;
               wait_cnt_next = '0;
            end else if (!i_Mem_Req) begin
               freeze        = 1'b0;
               state_next    = S_IDLE;
               wait_cnt_next = '0;
            end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
               state_next = S_ERROR;
            end else begin
               wait_cnt_next = wait_cnt + WAIT_W'(1);
            end
         end
         S_ERROR: begin
            freeze = 1'b1;
         end
         default: begin
            state_next    = S_IDLE;
            wait_cnt_next = '0;
         end
      endcase
   end

   assign exe_match1 = i_Exe_Wb_En & (i_Src1 == i_Exe_Dest);
   assign exe_match2 = i_Exe_Wb_En & (i_Src2 == i_Exe_Dest);
   assign mem_match1 = i_Mem_Wb_En & (i_Src1 == i_Mem_Dest);
   assign mem_match2 = i_Mem_Wb_En & (i_Src2 == i_Mem_Dest);

   // With forwarding, only a load in EX cannot be bypassed in time.
   always_comb begin
      hz = 1'b0;
      if (i_Forward_En)
         hz = i_Id_Valid & i_Exe_Mem_Read & (exe_match1 | (i_Two_Src & exe_match2));
      else
         hz = i_Id_Valid & (exe_match1 | mem_match1 | (i_Two_Src & (exe_match2 | mem_match2)));
   end

   assign o_Freeze      = freeze;
   assign o_Flush       = !freeze & i_Branch_Taken;
   assign o_Hazard      = !freeze & !i_Branch_Taken & hz;
   assign o_Mem_Timeout = (state == S_ERROR);

   always_ff @(posedge clk) begin
      if (!reset)
         o_Stall_Count <= '0;
      else if ((freeze || o_Hazard) && (o_Stall_Count != '1))
         o_Stall_Count <= o_Stall_Count + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// It uses a short timeout and a narrow counter so that the ERROR state and counter saturation are reachable quickly.
module tb_pipeline_hazard_ctrl;

   localparam int RW = 4;
   localparam int TO = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          id_valid, two_src, exe_wb_en, exe_mem_read, mem_wb_en, forward_en;
   logic [RW-1:0] src1, src2, exe_dest, mem_dest;
   logic          branch_taken, mem_req, mem_ready;
   logic          hazard, flush, freeze, mem_timeout;
   logic [CW-1:0] stall_count;

   int checkCount = 0;
   int passCount  = 0;

   pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RW), .MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .i_Id_Valid(id_valid), .i_Src1(src1), .i_Src2(src2), .i_Two_Src(two_src),
      .i_Exe_Dest(exe_dest), .i_Exe_Wb_En(exe_wb_en), .i_Exe_Mem_Read(exe_mem_read),
      .i_Mem_Dest(mem_dest), .i_Mem_Wb_En(mem_wb_en), .i_Forward_En(forward_en),
      .i_Branch_Taken(branch_taken), .i_Mem_Req(mem_req), .i_Mem_Ready(mem_ready),
      .o_Hazard(hazard), .o_Flush(flush), .o_Freeze(freeze),
      .o_Mem_Timeout(mem_timeout), .o_Stall_Count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
   endtask

   task automatic applyStimulus(input logic fwd, input logic valid, input logic [RW-1:0] s1,
                                input logic [RW-1:0] s2, input logic two,
                                input logic [RW-1:0] edst, input logic ewb, input logic eld,
                                input logic [RW-1:0] mdst, input logic mwb);
      forward_en   = fwd;
      id_valid     = valid;
      src1         = s1;
      src2         = s2;
      two_src      = two;
      exe_dest     = edst;
      exe_wb_en    = ewb;
      exe_mem_read = eld;
      mem_dest     = mdst;
      mem_wb_en    = mwb;
      #1;
   endtask

   task automatic setMem(input logic req, input logic rdy, input logic br);
      mem_req      = req;
      mem_ready    = rdy;
      branch_taken = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      setMem(0, 0, 0);
   endtask

   task automatic doReset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      clearInputs();
      tick();
      tick();
      checkOutput("rst_hazard", hazard, 0);
      checkOutput("rst_flush", flush, 0);
      checkOutput("rst_freeze", freeze, 0);
      checkOutput("rst_timeout", mem_timeout, 0);
      checkOutput("rst_count", stall_count, 0);
      reset = 1'b1;

      // Data hazards without forwarding
      applyStimulus(0, 1, 3, 0, 0, 3, 1, 0, 0, 0);
      checkOutput("nofwd_ex_src1", hazard, 1);
      applyStimulus(0, 1, 4, 3, 0, 3, 1, 0, 0, 0);
      checkOutput("nofwd_src2_unused", hazard, 0);
      applyStimulus(0, 1, 4, 3, 1, 3, 1, 0, 0, 0);
      checkOutput("nofwd_ex_src2", hazard, 1);
      applyStimulus(0, 1, 7, 0, 0, 2, 0, 0, 7, 1);
      checkOutput("nofwd_mem_src1", hazard, 1);
      applyStimulus(0, 0, 7, 0, 0, 2, 0, 0, 7, 1);
      checkOutput("nofwd_id_invalid", hazard, 0);

      // Forwarding: only load-use stalls
      applyStimulus(1, 1, 0, 5, 1, 5, 1, 0, 0, 0);
      checkOutput("fwd_alu_no_stall", hazard, 0);
      applyStimulus(1, 1, 0, 5, 1, 5, 1, 1, 0, 0);
      checkOutput("fwd_load_use", hazard, 1);
      applyStimulus(1, 1, 0, 5, 1, 5, 0, 1, 5, 1);
      checkOutput("fwd_mem_ignored", hazard, 0);

      // A branch squashes the ID instruction
      applyStimulus(1, 1, 0, 5, 1, 5, 1, 1, 0, 0);
      setMem(0, 0, 1);
      checkOutput("br_flush", flush, 1);
      checkOutput("br_hazard_masked", hazard, 0);

      // A 3-cycle memory wait
      clearInputs();
      doReset();
      setMem(1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("wait_freeze%0d", i), freeze, 1);
         tick();
      end
      setMem(1, 1, 0);
      checkOutput("ready_release", freeze, 0);
      tick();
      setMem(0, 0, 0);
      checkOutput("wait_count3", stall_count, 3);

      // A branch is deferred while the pipeline is frozen
      setMem(1, 0, 1);
      checkOutput("br_frz_freeze", freeze, 1);
      checkOutput("br_frz_noflush", flush, 0);
      tick();
      checkOutput("br_frz_noflush2", flush, 0);
      setMem(1, 1, 1);
      checkOutput("br_after_frz_flush", flush, 1);
      checkOutput("br_after_frz_freeze", freeze, 0);
      tick();

      // Abort from WAIT when the request drops, then a zero-wait access
      setMem(1, 0, 0);
      tick();
      setMem(0, 0, 0);
      checkOutput("abort_freeze", freeze, 0);
      tick();
      setMem(1, 1, 0);
      checkOutput("zero_wait", freeze, 0);
      tick();

      // Timeout after TO+1 frozen cycles
      clearInputs();
      doReset();
      setMem(1, 0, 0);
      for (int i = 0; i < TO + 1; i++) begin
         checkOutput($sformatf("to_freeze%0d", i), freeze, 1);
         checkOutput($sformatf("to_pending%0d", i), mem_timeout, 0);
         tick();
      end
      checkOutput("to_error", mem_timeout, 1);
      checkOutput("to_count", stall_count, TO + 1);
      setMem(0, 1, 1);
      checkOutput("err_freeze_held", freeze, 1);
      checkOutput("err_flush_masked", flush, 0);
      tick();
      checkOutput("err_sticky", mem_timeout, 1);
      clearInputs();
      doReset();
      checkOutput("err_rst_timeout", mem_timeout, 0);
      checkOutput("err_rst_freeze", freeze, 0);
      checkOutput("err_rst_count", stall_count, 0);

      // Stall counter saturation
      applyStimulus(0, 1, 3, 0, 0, 3, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++)
         tick();
      checkOutput("sat_hazard", hazard, 1);
      checkOutput("sat_count", stall_count, 15);

      // Reset in the middle of WAIT
      clearInputs();
      setMem(1, 0, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checkOutput("midwait_count", stall_count, 0);
      checkOutput("midwait_timeout", mem_timeout, 0);
      for (int i = 0; i < TO; i++)
         tick();
      checkOutput("midwait_restart", mem_timeout, 0);
      tick();
      checkOutput("midwait_error", mem_timeout, 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
